// File: rtl/can_rx_sequencer_if.sv
// rtl/can_rx_sequencer_if.sv - bus bundle between the CAN rx line, capture datapath and rx sequencer
//
// Signals
//   rx          raw CAN rx line (1 = recessive), asynchronous to clk
//   enable      0 forces the sequencer to IDLE_WAIT with outputs inactive
//   stuff_off   stuffed region over, destuffing disabled
//   frame_done  last field of the frame captured
//   cap_rst     one-clk clear of the capture datapath at SOF
//   cap_en      one-clk strobe, cap_bit holds a valid destuffed bit
//   cap_bit     destuffed sampled bit
//   busy        sequencer in SOF_CHK or FRAME
//   bus_idle    sequencer in READY
//   stuff_err   one-clk pulse on a stuff violation
//   frame_bits  destuffed bits since the last cap_rst, saturating at 255
// Modports
//   slave  : sequencer side
//   master : line / datapath side
interface can_rx_sequencer_if;
    logic       rx;
    logic       enable;
    logic       stuff_off;
    logic       frame_done;
    logic       cap_rst;
    logic       cap_en;
    logic       cap_bit;
    logic       busy;
    logic       bus_idle;
    logic       stuff_err;
    logic [7:0] frame_bits;

    modport slave (
        input  rx, enable, stuff_off, frame_done,
        output cap_rst, cap_en, cap_bit, busy, bus_idle, stuff_err, frame_bits
    );

    modport master (
        output rx, enable, stuff_off, frame_done,
        input  cap_rst, cap_en, cap_bit, busy, bus_idle, stuff_err, frame_bits
    );
endinterface

// File: rtl/can_rx_sequencer.sv
// rtl/can_rx_sequencer.sv - CAN rx bit timing, SOF hard sync and destuffing front end
//
// Parameters
//   BRP         clk cycles per time quantum (>=1)
//   TQ_PER_BIT  time quanta per bit (4..16)
//   SAMPLE_TQ   tq index at which rx is sampled (1..TQ_PER_BIT-1)
//   IDLE_BITS   consecutive recessive samples that declare the bus idle
// Ports
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   can_rx_sequencer_if.slave (rx/enable/stuff_off/frame_done in,
//         cap_rst/cap_en/cap_bit/busy/bus_idle/stuff_err/frame_bits out)
module can_rx_sequencer #(
    parameter int BRP        = 2,
    parameter int TQ_PER_BIT = 10,
    parameter int SAMPLE_TQ  = 7,
    parameter int IDLE_BITS  = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    can_rx_sequencer_if.slave     bus
);
    localparam int PW = (BRP > 1) ? $clog2(BRP) : 1;
    localparam int TW = $clog2(TQ_PER_BIT);
    localparam int IW = $clog2(IDLE_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE_WAIT,
        S_READY,
        S_SOF_CHK,
        S_FRAME,
        S_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_s_q, rx_prev_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [TW-1:0] tq_q, tq_d;
    logic [IW-1:0] idle_q, idle_d, idle_inc;
    logic [2:0]    run_q, run_d;
    logic          last_q, last_d;
    logic [7:0]    fb_q, fb_d;
    logic          cap_rst_q, cap_rst_d;
    logic          cap_en_q, cap_en_d;
    logic          cap_bit_q, cap_bit_d;
    logic          stuff_err_q, stuff_err_d;
    logic          busy_q, busy_d;
    logic          bus_idle_q, bus_idle_d;

    logic fall;
    logic sample;

    assign fall   = rx_prev_q & ~rx_s_q;
    assign sample = (tq_q == TW'(SAMPLE_TQ)) && (presc_q == '0);

    always_comb begin
        state_d     = state_q;
        idle_d      = idle_q;
        run_d       = run_q;
        last_d      = last_q;
        fb_d        = fb_q;
        cap_rst_d   = 1'b0;
        cap_en_d    = 1'b0;
        cap_bit_d   = cap_bit_q;
        stuff_err_d = 1'b0;
        idle_inc    = rx_s_q ? (idle_q + IW'(1)) : '0;

        // Free-running bit timer; READY and the SOF hard sync override it below.
        if (presc_q == PW'(BRP - 1)) begin
            presc_d = '0;
            tq_d    = (tq_q == TW'(TQ_PER_BIT - 1)) ? '0 : (tq_q + TW'(1));
        end else begin
            presc_d = presc_q + PW'(1);
            tq_d    = tq_q;
        end

        case (state_q)
            S_IDLE_WAIT, S_ERROR: begin
                if (sample) begin
                    if (idle_inc == IW'(IDLE_BITS)) begin
                        state_d = S_READY;
                        idle_d  = '0;
                        presc_d = '0;
                        tq_d    = '0;
                    end else begin
                        idle_d = idle_inc;
                    end
                end
            end
            S_READY: begin
                // Timer parked at zero, so leaving on the falling edge is the hard sync.
                presc_d = '0;
                tq_d    = '0;
                if (fall) begin
                    state_d = S_SOF_CHK;
                end
            end
            S_SOF_CHK: begin
                if (sample) begin
                    if (!rx_s_q) begin
                        cap_rst_d = 1'b1;
                        fb_d      = '0;
                        run_d     = 3'd1;
                        last_d    = 1'b0;
                        state_d   = S_FRAME;
                    end else begin
                        state_d = S_READY;
                        presc_d = '0;
                        tq_d    = '0;
                    end
                end
            end
            S_FRAME: begin
                if (bus.frame_done) begin
                    state_d = S_IDLE_WAIT;
                    idle_d  = '0;
                end
                // A bit sampled in the same clk as frame_done is still emitted.
                if (sample) begin
                    if (!bus.stuff_off && (run_q == 3'd5)) begin
                        if (rx_s_q != last_q) begin
                            run_d  = 3'd1;
                            last_d = rx_s_q;
                        end else begin
                            stuff_err_d = 1'b1;
                            state_d     = S_ERROR;
                            idle_d      = '0;
                        end
                    end else begin
                        cap_en_d  = 1'b1;
                        cap_bit_d = rx_s_q;
                        if (fb_q != 8'hFF) begin
                            fb_d = fb_q + 8'd1;
                        end
                        // Saturate so long unstuffed runs never wrap back to 5.
                        if (rx_s_q == last_q) begin
                            run_d = (run_q == 3'd7) ? run_q : (run_q + 3'd1);
                        end else begin
                            run_d = 3'd1;
                        end
                        last_d = rx_s_q;
                    end
                end
            end
            default: begin
                state_d = S_IDLE_WAIT;
            end
        endcase

        if (!bus.enable) begin
            state_d     = S_IDLE_WAIT;
            presc_d     = '0;
            tq_d        = '0;
            idle_d      = '0;
            run_d       = '0;
            last_d      = 1'b0;
            fb_d        = '0;
            cap_rst_d   = 1'b0;
            cap_en_d    = 1'b0;
            cap_bit_d   = 1'b0;
            stuff_err_d = 1'b0;
        end

        busy_d     = (state_d == S_SOF_CHK) || (state_d == S_FRAME);
        bus_idle_d = (state_d == S_READY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Synchronizer parks recessive so reset release cannot fake an SOF edge.
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= S_IDLE_WAIT;
            presc_q     <= '0;
            tq_q        <= '0;
            idle_q      <= '0;
            run_q       <= '0;
            last_q      <= 1'b0;
            fb_q        <= '0;
            cap_rst_q   <= 1'b0;
            cap_en_q    <= 1'b0;
            cap_bit_q   <= 1'b0;
            stuff_err_q <= 1'b0;
            busy_q      <= 1'b0;
            bus_idle_q  <= 1'b0;
        end else begin
            rx_meta_q   <= bus.rx;
            rx_s_q      <= rx_meta_q;
            rx_prev_q   <= rx_s_q;
            state_q     <= state_d;
            presc_q     <= presc_d;
            tq_q        <= tq_d;
            idle_q      <= idle_d;
            run_q       <= run_d;
            last_q      <= last_d;
            fb_q        <= fb_d;
            cap_rst_q   <= cap_rst_d;
            cap_en_q    <= cap_en_d;
            cap_bit_q   <= cap_bit_d;
            stuff_err_q <= stuff_err_d;
            busy_q      <= busy_d;
            bus_idle_q  <= bus_idle_d;
        end
    end

    assign bus.cap_rst    = cap_rst_q;
    assign bus.cap_en     = cap_en_q;
    assign bus.cap_bit    = cap_bit_q;
    assign bus.busy       = busy_q;
    assign bus.bus_idle   = bus_idle_q;
    assign bus.stuff_err  = stuff_err_q;
    assign bus.frame_bits = fb_q;
endmodule

// File: tb/tb_can_rx_sequencer.sv
// tb/tb_can_rx_sequencer.sv - randomized self-checking bench for can_rx_sequencer
module tb_can_rx_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    int   en_cyc[$];
    bit   en_bit[$];
    int   rst_cyc[$];
    int   err_cyc[$];

    always #5 clk = ~clk;

    can_rx_sequencer_if bus();

    can_rx_sequencer #(
        .BRP(2), .TQ_PER_BIT(10), .SAMPLE_TQ(7), .IDLE_BITS(11)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.cap_en === 1'b1) begin
            en_cyc.push_back(cyc);
            en_bit.push_back(bus.cap_bit);
        end
        if (bus.cap_rst === 1'b1) rst_cyc.push_back(cyc);
        if (bus.stuff_err === 1'b1) err_cyc.push_back(cyc);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        en_cyc.delete();
        en_bit.delete();
        rst_cyc.delete();
        err_cyc.delete();
    endtask

    // Bus idle is reached 11 recessive bit times after rx returns high,
    // give or take one bit of timer phase.
    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (bus.bus_idle !== 1'b1 && k < 300) begin
            tick();
            k++;
        end
        check({tag, " idle_lat"}, (k >= 195 && k <= 240), 1);
        check({tag, " idle_busy"}, bus.busy, 0);
    endtask

    // One frame: SOF bit then bits[], 20 clk per bit; stuff_off from bit so_from (0 = never).
    task automatic run_frame(input string tag, input bit bits[$], input int so_from);
        int  exp_c[$];
        bit  exp_b[$];
        int  err_at;
        int  run;
        bit  last;
        bit  so;
        int  n0;
        err_at = -1;
        run    = 1;
        last   = 1'b0;
        for (int j = 1; j <= bits.size(); j++) begin
            so = (so_from >= 1) && (j >= so_from);
            if (!so && run == 5) begin
                if (bits[j-1] != last) begin
                    run  = 1;
                    last = bits[j-1];
                end else begin
                    err_at = j;
                    break;
                end
            end else begin
                exp_c.push_back(18 + 20 * j);
                exp_b.push_back(bits[j-1]);
                run  = (bits[j-1] == last) ? run + 1 : 1;
                last = bits[j-1];
            end
        end

        clear_mon();
        n0 = cyc;
        bus.rx        = 1'b0;
        bus.stuff_off = 1'b0;
        tick(20);
        check({tag, " busy"}, bus.busy, 1);
        for (int j = 1; j <= bits.size(); j++) begin
            if (err_at >= 0 && j > err_at) break;
            bus.rx        = bits[j-1];
            bus.stuff_off = (so_from >= 1) && (j >= so_from);
            tick(20);
        end
        if (err_at < 0) begin
            check({tag, " frame_bits"}, bus.frame_bits, (exp_c.size() > 255) ? 255 : exp_c.size());
            bus.frame_done = 1'b1;
            tick();
            bus.frame_done = 1'b0;
        end
        bus.rx        = 1'b1;
        bus.stuff_off = 1'b0;
        wait_idle(tag);

        check({tag, " cap_rst_n"}, rst_cyc.size(), 1);
        if (rst_cyc.size() >= 1) check({tag, " cap_rst_t"}, rst_cyc[0] - n0, 18);
        check({tag, " cap_en_n"}, en_cyc.size(), exp_c.size());
        for (int i = 0; i < exp_c.size() && i < en_cyc.size(); i++) begin
            check($sformatf("%s en_t%0d", tag, i), en_cyc[i] - n0, exp_c[i]);
            check($sformatf("%s en_b%0d", tag, i), en_bit[i], exp_b[i]);
        end
        check({tag, " stuff_err_n"}, err_cyc.size(), (err_at >= 0) ? 1 : 0);
        if (err_at >= 0 && err_cyc.size() >= 1)
            check({tag, " stuff_err_t"}, err_cyc[0] - n0, 18 + 20 * err_at);
    endtask

    task automatic gen(output bit q[$], input int n, input bit comply);
        bit prev;
        bit b;
        int run;
        q.delete();
        prev = 1'b0;
        run  = 1;
        for (int i = 0; i < n; i++) begin
            if (comply && run == 5) b = ~prev;
            else b = ($urandom_range(3) == 0) ? ~prev : prev;
            run  = (b == prev) ? run + 1 : 1;
            prev = b;
            q.push_back(b);
        end
    endtask

    initial begin
        bit q[$];
        int first;
        int n0;

        rst            = 1'b1;
        bus.rx         = 1'b1;
        bus.enable     = 1'b1;
        bus.stuff_off  = 1'b0;
        bus.frame_done = 1'b0;
        tick(3);
        check("rst cap_en", bus.cap_en, 0);
        check("rst cap_rst", bus.cap_rst, 0);
        check("rst busy", bus.busy, 0);
        check("rst bus_idle", bus.bus_idle, 0);
        check("rst stuff_err", bus.stuff_err, 0);
        check("rst frame_bits", bus.frame_bits, 0);

        // 11 recessive samples: first at clk 14 after reset, then every 20 clk.
        rst   = 1'b0;
        first = -1;
        for (int i = 1; i <= 230; i++) begin
            tick();
            if (bus.bus_idle === 1'b1 && first < 0) first = i;
        end
        check("idle after reset", first, 215);

        // Short low glitch: SOF check samples recessive, back to READY.
        clear_mon();
        bus.rx = 1'b0;
        tick(4);
        bus.rx = 1'b1;
        tick(2);
        check("glitch busy", bus.busy, 1);
        tick(20);
        check("glitch ready", bus.bus_idle, 1);
        check("glitch no cap_rst", rst_cyc.size(), 0);

        q = '{0, 0, 0, 0, 1, 1, 0};
        run_frame("stuff_ok", q, 0);
        q = '{0, 0, 0, 0, 0, 1};
        run_frame("stuff_err", q, 0);
        q = '{0, 0, 0, 0, 0, 0, 0};
        run_frame("stuff_off", q, 1);

        // enable dropped in the clk of bit 2's sample: its cap_en must not appear.
        clear_mon();
        bus.rx = 1'b0;
        tick(20);
        bus.rx = 1'b1;
        tick(20);
        bus.rx = 1'b0;
        tick(17);
        bus.enable = 1'b0;
        tick();
        check("en_off cap_en", bus.cap_en, 0);
        check("en_off busy", bus.busy, 0);
        check("en_off frame_bits", bus.frame_bits, 0);
        bus.enable = 1'b1;
        bus.rx     = 1'b1;
        wait_idle("en_off");
        check("en_off n_en", en_cyc.size(), 1);

        // Reset mid-frame.
        clear_mon();
        bus.rx = 1'b0;
        tick(20);
        bus.rx = 1'b1;
        tick(30);
        check("rst_mid frame_bits pre", bus.frame_bits, 1);
        rst = 1'b1;
        tick();
        check("rst_mid busy", bus.busy, 0);
        check("rst_mid frame_bits", bus.frame_bits, 0);
        check("rst_mid cap_en", bus.cap_en, 0);
        rst = 1'b0;
        wait_idle("rst_mid");

        for (int f = 0; f < 8; f++) begin
            int n;
            int so_from;
            n       = $urandom_range(6, 24);
            so_from = ($urandom_range(1) == 1) ? $urandom_range(3, n) : 0;
            gen(q, n, ($urandom_range(3) != 0));
            run_frame($sformatf("rnd%0d", f), q, so_from);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
